// File: rtl/led_matrix_pkg.sv
// Shared types for the 8x8 LED matrix scan path: scan states, row index/data types
// and the row-strobe encoder used by the scan controller.
package led_matrix_pkg;

   localparam int MATRIX_ROWS = 8;
   localparam int MATRIX_COLS = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      SHOW  = 2'd2
   } scan_state_t;

   typedef logic [$clog2(MATRIX_ROWS)-1:0] row_idx_t;
   typedef logic [MATRIX_COLS-1:0]         row_t;
   typedef logic [MATRIX_ROWS-1:0]         row_sel_t;

   function automatic row_sel_t row_strobe(input row_idx_t row, input logic active_low);
      row_sel_t w_onehot;
      w_onehot = row_sel_t'(1) << row;
      return active_low ? ~w_onehot : w_onehot;
   endfunction

endpackage

// File: rtl/led_frame_bank.sv
// Double-buffered 8x8 frame store: writes always land in the back bank, the combinational
// read port sees the front bank; no backpressure, toggle swaps the banks on the next edge.
module led_frame_bank
   import led_matrix_pkg::*;
(
   input  logic     clk,
   input  logic     reset,
   input  logic     wr_en,
   input  row_idx_t wr_row,
   input  row_t     wr_data,
   input  logic     toggle,
   input  row_idx_t rd_row,
   output row_t     rd_data
);

   row_t [1:0][MATRIX_ROWS-1:0] r_bank;
   logic                        r_front;

   // A write coinciding with toggle targets the pre-swap back bank, which becomes front.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_bank  <= '0;
         r_front <= 1'b0;
      end else begin
         if (wr_en) begin
            r_bank[~r_front][wr_row] <= wr_data;
         end
         if (toggle) begin
            r_front <= ~r_front;
         end
      end
   end

   assign rd_data = r_bank[r_front][rd_row];

endmodule

// File: rtl/led_matrix_scan_ctrl.sv
// Row-scan controller: blank gap, then one row lit for a dwell period; outputs registered and
// track the scan state with no added lag. Host writes never stall; swaps wait for frame end.
module led_matrix_scan_ctrl
   import led_matrix_pkg::*;
#(
   parameter int DWELL_CYCLES   = 1024,
   parameter int BLANK_CYCLES   = 16,
   parameter int ROW_ACTIVE_LOW = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       wr_en,
   input  logic [2:0] wr_row,
   input  logic [7:0] wr_data,
   input  logic       swap_req,
   output logic       swap_pending,
   output logic       swap_ack,
   output logic [7:0] row_sel,
   output logic [7:0] col_data,
   output logic       frame_tick
);

   localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
   localparam logic     ACT_LOW = (ROW_ACTIVE_LOW != 0);
   localparam row_sel_t ROW_OFF = ACT_LOW ? 8'hFF : 8'h00;

   scan_state_t      r_state;
   scan_state_t      w_state_nxt;
   row_idx_t         r_row;
   row_idx_t         w_row_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_frame_end;
   logic             w_swap;
   row_t             w_front_rd;

   logic             r_swap_pending;
   logic             r_swap_ack;
   logic             r_frame_tick;
   row_sel_t         r_row_sel;
   row_t             r_col_data;

   always_comb begin
      w_state_nxt = r_state;
      w_row_nxt   = r_row;
      w_cnt_nxt   = r_cnt;
      w_frame_end = 1'b0;
      if (!enable) begin
         w_state_nxt = IDLE;
         w_row_nxt   = '0;
         w_cnt_nxt   = '0;
      end else begin
         case (r_state)
            IDLE: begin
               w_state_nxt = BLANK;
               w_row_nxt   = '0;
               w_cnt_nxt   = '0;
            end
            BLANK: begin
               if (r_cnt == BLANK_LAST) begin
                  w_state_nxt = SHOW;
                  w_cnt_nxt   = '0;
               end else begin
                  w_cnt_nxt = r_cnt + CNT_W'(1);
               end
            end
            SHOW: begin
               if (r_cnt == DWELL_LAST) begin
                  w_state_nxt = BLANK;
                  w_cnt_nxt   = '0;
                  w_row_nxt   = r_row + row_idx_t'(1);
                  w_frame_end = (r_row == row_idx_t'(MATRIX_ROWS - 1));
               end else begin
                  w_cnt_nxt = r_cnt + CNT_W'(1);
               end
            end
            default: begin
               w_state_nxt = IDLE;
               w_row_nxt   = '0;
               w_cnt_nxt   = '0;
            end
         endcase
      end
   end

   assign w_swap = w_frame_end & r_swap_pending;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_row   <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_row   <= w_row_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Outputs are registered from the next-state decode so they switch on the same edge as the state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_swap_pending <= 1'b0;
         r_swap_ack     <= 1'b0;
         r_frame_tick   <= 1'b0;
         r_row_sel      <= ROW_OFF;
         r_col_data     <= '0;
      end else begin
         r_frame_tick <= w_frame_end;
         r_swap_ack   <= w_swap;
         if (w_swap) begin
            r_swap_pending <= swap_req;
         end else if (swap_req) begin
            r_swap_pending <= 1'b1;
         end
         if (w_state_nxt == SHOW) begin
            r_row_sel  <= row_strobe(w_row_nxt, ACT_LOW);
            r_col_data <= w_front_rd;
         end else begin
            r_row_sel  <= ROW_OFF;
            r_col_data <= '0;
         end
      end
   end

   led_frame_bank u_bank (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_en),
      .wr_row  (wr_row),
      .wr_data (wr_data),
      .toggle  (w_swap),
      .rd_row  (w_row_nxt),
      .rd_data (w_front_rd)
   );

   assign swap_pending = r_swap_pending;
   assign swap_ack     = r_swap_ack;
   assign frame_tick   = r_frame_tick;
   assign row_sel      = r_row_sel;
   assign col_data     = r_col_data;

endmodule

// File: tb/tb_led_matrix_scan_ctrl.sv
// Directed bench for led_matrix_scan_ctrl (DWELL=4, BLANK=2): an active-low instance and an
// active-high instance share all inputs, so the row-strobe polarity variant is checked alongside.
module tb_led_matrix_scan_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       enable;
   logic       wr_en;
   logic [2:0] wr_row;
   logic [7:0] wr_data;
   logic       swap_req;

   logic       pend_a, ack_a, tick_a;
   logic [7:0] sel_a, col_a;
   logic       pend_b, ack_b, tick_b;
   logic [7:0] sel_b, col_b;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [7:0] wdata;
      logic [7:0] sel_al;
      logic [7:0] sel_ah;
   } row_vec_t;
   row_vec_t vec [8];

   led_matrix_scan_ctrl #(.DWELL_CYCLES(4), .BLANK_CYCLES(2), .ROW_ACTIVE_LOW(1)) u_dut_al (
      .clk(clk), .reset(reset), .enable(enable), .wr_en(wr_en), .wr_row(wr_row),
      .wr_data(wr_data), .swap_req(swap_req), .swap_pending(pend_a), .swap_ack(ack_a),
      .row_sel(sel_a), .col_data(col_a), .frame_tick(tick_a)
   );

   led_matrix_scan_ctrl #(.DWELL_CYCLES(4), .BLANK_CYCLES(2), .ROW_ACTIVE_LOW(0)) u_dut_ah (
      .clk(clk), .reset(reset), .enable(enable), .wr_en(wr_en), .wr_row(wr_row),
      .wr_data(wr_data), .swap_req(swap_req), .swap_pending(pend_b), .swap_ack(ack_b),
      .row_sel(sel_b), .col_data(col_b), .frame_tick(tick_b)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Runs until frame_tick, capturing col_data while row_sel==match and counting swap_ack pulses.
   task automatic frame_scan(input logic [7:0] match, output logic [7:0] cap,
                             output int acks, output int cycles);
      bit done;
      done   = 1'b0;
      cap    = 8'hEE;
      acks   = 0;
      cycles = 0;
      for (int i = 0; i < 100 && !done; i++) begin
         step();
         cycles++;
         if (sel_a == match) cap = col_a;
         if (ack_a) acks++;
         if (tick_a) done = 1'b1;
      end
      chk("scan_bound", 32'(done), 1);
   endtask

   task automatic scan_expect(input string nm, input logic [7:0] match, input logic [7:0] exp_col,
                              input int exp_acks, input int exp_cyc);
      logic [7:0] cap;
      int         acks;
      int         cycles;
      frame_scan(match, cap, acks, cycles);
      chk({nm, "_col"}, 32'(cap), 32'(exp_col));
      chk({nm, "_acks"}, acks, exp_acks);
      if (exp_cyc > 0) chk({nm, "_cycles"}, cycles, exp_cyc);
   endtask

   initial begin
      int  cyc;
      int  ev;
      bit  got;

      reset = 1'b1; enable = 1'b0; wr_en = 1'b0; wr_row = '0; wr_data = '0; swap_req = 1'b0;
      vec[0] = '{8'h01, 8'hFE, 8'h01};
      vec[1] = '{8'h02, 8'hFD, 8'h02};
      vec[2] = '{8'h04, 8'hFB, 8'h04};
      vec[3] = '{8'h08, 8'hF7, 8'h08};
      vec[4] = '{8'h10, 8'hEF, 8'h10};
      vec[5] = '{8'h20, 8'hDF, 8'h20};
      vec[6] = '{8'h40, 8'hBF, 8'h40};
      vec[7] = '{8'h80, 8'h7F, 8'h80};

      step(); step();
      chk("rst_sel", 32'(sel_a), 32'hFF);
      chk("rst_col", 32'(col_a), 0);
      chk("rst_flags", {pend_a, ack_a, tick_a}, 0);
      chk("rst_b", {sel_b, col_b, pend_b, ack_b, tick_b}, 0);
      reset = 1'b0;

      for (int i = 0; i < 100; i++) begin
         step();
         chk("idle_hold", {sel_a, col_a, pend_a, ack_a, tick_a, sel_b}, {8'hFF, 8'h00, 3'b000, 8'h00});
      end

      for (int r = 0; r < 8; r++) begin
         wr_en = 1'b1; wr_row = 3'(r); wr_data = vec[r].wdata;
         step();
      end
      wr_en = 1'b0; swap_req = 1'b1;
      step();
      swap_req = 1'b0;
      chk("pend_set", 32'(pend_a), 1);

      // First frame shows the cleared bank; swap lands at its end.
      enable = 1'b1;
      cyc = 0; got = 1'b0;
      for (int i = 0; i < 200 && !got; i++) begin
         step();
         cyc++;
         if (ack_a) got = 1'b1;
      end
      chk("first_ack_seen", 32'(got), 1);
      chk("first_ack_lat", cyc, 49);
      chk("first_tick", 32'(tick_a), 1);
      chk("pend_clr", 32'(pend_a), 0);

      for (int r = 0; r < 8; r++) begin
         for (int d = 0; d < 2; d++) begin
            if (r != 0 || d != 0) step();
            chk("blank", {sel_a, col_a, sel_b}, {8'hFF, 8'h00, 8'h00});
         end
         for (int s = 0; s < 4; s++) begin
            step();
            chk("show_sel", 32'(sel_a), 32'(vec[r].sel_al));
            chk("show_col", 32'(col_a), 32'(vec[r].wdata));
            chk("show_sel_ah", 32'(sel_b), 32'(vec[r].sel_ah));
            chk("show_no_tick", 32'(tick_a), 0);
         end
      end
      step();
      chk("tick_period", 32'(tick_a), 1);
      chk("tick_no_ack", 32'(ack_a), 0);

      // Back-buffer write without swap stays invisible.
      repeat (10) step();
      wr_en = 1'b1; wr_row = 3'd3; wr_data = 8'hAA;
      step();
      wr_en = 1'b0;
      scan_expect("keep1", 8'hF7, 8'h08, 0, 0);
      scan_expect("keep2", 8'hF7, 8'h08, 0, 48);
      scan_expect("keep3", 8'hF7, 8'h08, 0, 48);
      step(); step();
      swap_req = 1'b1;
      step();
      swap_req = 1'b0;
      chk("pend2", 32'(pend_a), 1);
      scan_expect("swap_pre", 8'hF7, 8'h08, 1, 0);
      scan_expect("swap_post", 8'hF7, 8'hAA, 0, 48);

      // Two requests in one frame -> a single swap.
      step(); step();
      swap_req = 1'b1; step(); swap_req = 1'b0;
      step(); step();
      swap_req = 1'b1; step(); swap_req = 1'b0;
      scan_expect("dbl_a", 8'hF7, 8'hAA, 1, 0);
      scan_expect("dbl_b", 8'hF7, 8'h08, 0, 48);

      // Request coincident with swap_ack re-arms for the following frame.
      step(); step();
      swap_req = 1'b1; step(); swap_req = 1'b0;
      scan_expect("coinc_a", 8'hF7, 8'h08, 1, 0);
      chk("coinc_ack", 32'(ack_a), 1);
      swap_req = 1'b1;
      step();
      swap_req = 1'b0;
      chk("coinc_pend", 32'(pend_a), 1);
      scan_expect("coinc_b", 8'hF7, 8'hAA, 1, 47);
      scan_expect("coinc_c", 8'hF7, 8'h08, 0, 48);

      // Write in the very cycle the swap is applied.
      swap_req = 1'b1; step(); swap_req = 1'b0;
      repeat (46) step();
      chk("row7_last", 32'(sel_a), 32'h7F);
      wr_en = 1'b1; wr_row = 3'd0; wr_data = 8'h5A;
      step();
      wr_en = 1'b0;
      chk("wswap_ack", 32'(ack_a), 1);
      chk("wswap_tick", 32'(tick_a), 1);
      scan_expect("wswap_row0", 8'hFE, 8'h5A, 0, 48);

      // Disable during row 5 with a swap pending.
      swap_req = 1'b1; step(); swap_req = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 60 && !got; i++) begin
         step();
         if (sel_a == 8'hDF) got = 1'b1;
      end
      chk("wait_row5", 32'(got), 1);
      enable = 1'b0;
      step();
      chk("dis_dark", {sel_a, col_a, sel_b}, {8'hFF, 8'h00, 8'h00});
      chk("dis_pend", 32'(pend_a), 1);
      ev = 0;
      for (int i = 0; i < 60; i++) begin
         step();
         if (ack_a || tick_a || sel_a != 8'hFF) ev++;
      end
      chk("dis_quiet", ev, 0);
      chk("dis_pend2", 32'(pend_a), 1);
      enable = 1'b1;
      step();
      chk("re_blank0", {sel_a, col_a}, {8'hFF, 8'h00});
      step();
      chk("re_blank1", {sel_a, col_a}, {8'hFF, 8'h00});
      step();
      chk("re_sel", 32'(sel_a), 32'hFE);
      chk("re_col", 32'(col_a), 32'h5A);
      scan_expect("re_swap", 8'hFE, 8'h5A, 1, 46);

      // Asynchronous reset mid-SHOW.
      step(); step();
      chk("pre_rst_sel", 32'(sel_a), 32'hFE);
      chk("pre_rst_col", 32'(col_a), 32'h01);
      #3;
      reset = 1'b1;
      #1;
      chk("arst_dark", {sel_a, col_a, sel_b, col_b}, {8'hFF, 8'h00, 8'h00, 8'h00});
      step(); step();
      reset = 1'b0;
      step(); step(); step();
      chk("post_rst_sel", 32'(sel_a), 32'hFE);
      chk("post_rst_sel_ah", 32'(sel_b), 32'h01);
      chk("post_rst_col", 32'(col_a), 0);
      chk("post_rst_pend", 32'(pend_a), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
